mem_req_arbiter: RTL and testbench

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_req_arbiter.sv | 102 ++++++++++
 tb/tb_mem_req_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: arbitrates data-cache write-back and refill requests onto one memory port.
// One outstanding transaction; each response wait is bounded by a saturating timeout counter.
module mem_req_arbiter #(
  parameter int TMO_W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         dcw_start_rq,
  input  logic [31:0]  dcw_in_addr,
  input  logic [15:0]  dcw_in_mask,
  input  logic [127:0] dcw_in_data,
  output logic         dcw_finish_wresp,
  input  logic         dcr_start_rq,
  input  logic [31:0]  dcr_rin_addr,
  output logic [127:0] rdat_m_data,
  output logic         rdat_m_valid,
  output logic         finish_mrd,
  output logic         rqfull_1,
  output logic         wqfull,
  output logic         mem_cmd_valid,
  input  logic         mem_cmd_ready,
  output logic         mem_cmd_we,
  output logic [31:0]  mem_cmd_addr,
  output logic [15:0]  mem_cmd_mask,
  output logic [127:0] mem_cmd_wdata,
  input  logic         mem_wresp,
  input  logic [127:0] mem_rdata,
  input  logic         mem_rvalid,
  input  logic         mem_rlast,
  input  logic         err_clr,
  output logic         ovf_err,
  output logic         tmo_err
);
  typedef enum logic [2:0] {IDLE, WR_CMD, WR_WAIT, RD_CMD, RD_WAIT} state_t;
  // counter equals this value during the (2^TMO_W-1)-th wait cycle
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((1 << TMO_W) - 2);
  state_t state, state_nx;
  logic [31:0] w_addr, r_addr;
  logic [15:0] w_mask;
  logic [127:0] w_data;
  logic last_wr;
  logic [TMO_W-1:0] cnt;
  logic wr_hs, rd_hs, waiting, beat, tmo_hit, w_ovf, r_ovf;
  assign wr_hs = state == WR_CMD && mem_cmd_ready;
  assign rd_hs = state == RD_CMD && mem_cmd_ready;
  assign waiting = state == WR_WAIT || state == RD_WAIT;
  assign beat = state == RD_WAIT && mem_rvalid;
  assign tmo_hit = waiting && !beat && cnt == TMO_LAST;
  assign w_ovf = dcw_start_rq && wqfull && !wr_hs;
  assign r_ovf = dcr_start_rq && rqfull_1 && !rd_hs;
  assign mem_cmd_valid = state == WR_CMD || state == RD_CMD;
  assign mem_cmd_we = state == WR_CMD;
  assign mem_cmd_addr = state == WR_CMD ? w_addr : state == RD_CMD ? r_addr : '0;
  assign mem_cmd_mask = state == WR_CMD ? w_mask : '0;
  assign mem_cmd_wdata = state == WR_CMD ? w_data : '0;
  assign dcw_finish_wresp = state == WR_WAIT && (mem_wresp || tmo_hit);
  assign rdat_m_valid = beat;
  assign rdat_m_data = state == RD_WAIT ? mem_rdata : '0;
  assign finish_mrd = state == RD_WAIT && ((mem_rvalid && mem_rlast) || tmo_hit);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = wqfull && (!rqfull_1 || !last_wr) ? WR_CMD : rqfull_1 ? RD_CMD : IDLE;
      WR_CMD:  state_nx = mem_cmd_ready ? WR_WAIT : WR_CMD;
      RD_CMD:  state_nx = mem_cmd_ready ? RD_WAIT : RD_CMD;
      WR_WAIT: state_nx = mem_wresp || tmo_hit ? IDLE : WR_WAIT;
      RD_WAIT: state_nx = (mem_rvalid && mem_rlast) || tmo_hit ? IDLE : RD_WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last_wr <= 1'b0;
      wqfull <= 1'b0;
      rqfull_1 <= 1'b0;
      w_addr <= '0;
      w_mask <= '0;
      w_data <= '0;
      r_addr <= '0;
      cnt <= '0;
      ovf_err <= 1'b0;
      tmo_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && state_nx != IDLE) last_wr <= state_nx == WR_CMD;
      if (dcw_start_rq && !w_ovf) begin
        wqfull <= 1'b1;
        w_addr <= dcw_in_addr;
        w_mask <= dcw_in_mask;
        w_data <= dcw_in_data;
      end else if (wr_hs) wqfull <= 1'b0;
      if (dcr_start_rq && !r_ovf) begin
        rqfull_1 <= 1'b1;
        r_addr <= dcr_rin_addr;
      end else if (rd_hs) rqfull_1 <= 1'b0;
      cnt <= wr_hs || rd_hs || beat ? '0 : waiting && cnt != '1 ? cnt + 1'b1 : cnt;
      ovf_err <= w_ovf || r_ovf || (ovf_err && !err_clr);
      tmo_err <= tmo_hit || (tmo_err && !err_clr);
    end
  end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed checks of arbitration, handshakes, overflow, timeout and reset.
`define CHK(tag, obs, exp) chk(tag, 128'(obs), 128'(exp))
module tb_mem_req_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic dcw_start_rq, dcr_start_rq, dcw_finish_wresp, rdat_m_valid, finish_mrd, rqfull_1, wqfull;
  logic [31:0] dcw_in_addr, dcr_rin_addr, mem_cmd_addr;
  logic [15:0] dcw_in_mask, mem_cmd_mask;
  logic [127:0] dcw_in_data, rdat_m_data, mem_cmd_wdata, mem_rdata;
  logic mem_cmd_valid, mem_cmd_ready, mem_cmd_we, mem_wresp, mem_rvalid, mem_rlast;
  logic err_clr, ovf_err, tmo_err;
  int passed = 0;
  int total = 0;

  mem_req_arbiter #(.TMO_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .dcw_start_rq(dcw_start_rq), .dcw_in_addr(dcw_in_addr), .dcw_in_mask(dcw_in_mask),
    .dcw_in_data(dcw_in_data), .dcw_finish_wresp(dcw_finish_wresp),
    .dcr_start_rq(dcr_start_rq), .dcr_rin_addr(dcr_rin_addr),
    .rdat_m_data(rdat_m_data), .rdat_m_valid(rdat_m_valid), .finish_mrd(finish_mrd),
    .rqfull_1(rqfull_1), .wqfull(wqfull),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_mask(mem_cmd_mask), .mem_cmd_wdata(mem_cmd_wdata),
    .mem_wresp(mem_wresp), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_rlast(mem_rlast),
    .err_clr(err_clr), .ovf_err(ovf_err), .tmo_err(tmo_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic serve_wr(input logic [31:0] a, input logic [15:0] m, input logic [127:0] d, input int dly);
    #1;
    `CHK("wr_valid", mem_cmd_valid, 1);
    `CHK("wr_we", mem_cmd_we, 1);
    `CHK("wr_addr", mem_cmd_addr, a);
    `CHK("wr_mask", mem_cmd_mask, m);
    `CHK("wr_data", mem_cmd_wdata, d);
    tick();
    `CHK("wr_slot_clr", wqfull, 0);
    repeat (dly - 1) begin
      `CHK("wr_wait_nofin", dcw_finish_wresp, 0);
      `CHK("wr_wait_nocmd", mem_cmd_valid, 0);
      tick();
    end
    mem_wresp = 1'b1;
    #1;
    `CHK("wr_finish", dcw_finish_wresp, 1);
    tick();
    mem_wresp = 1'b0;
    #1;
    `CHK("wr_finish_once", dcw_finish_wresp, 0);
    `CHK("wr_idle", mem_cmd_valid, 0);
    tick();
  endtask

  task automatic serve_rd(input logic [31:0] a, input logic [127:0] d);
    #1;
    `CHK("rd_valid", mem_cmd_valid, 1);
    `CHK("rd_we", mem_cmd_we, 0);
    `CHK("rd_addr", mem_cmd_addr, a);
    `CHK("rd_mask_zero", mem_cmd_mask, 0);
    `CHK("rd_wdata_zero", mem_cmd_wdata, 0);
    tick();
    `CHK("rd_slot_clr", rqfull_1, 0);
    mem_rvalid = 1'b1;
    mem_rlast = 1'b1;
    mem_rdata = d;
    #1;
    `CHK("rd_beat_valid", rdat_m_valid, 1);
    `CHK("rd_beat_data", rdat_m_data, d);
    `CHK("rd_finish", finish_mrd, 1);
    tick();
    mem_rvalid = 1'b0;
    mem_rlast = 1'b0;
    #1;
    `CHK("rd_finish_once", finish_mrd, 0);
    `CHK("rd_idle", mem_cmd_valid, 0);
    tick();
  endtask

  task automatic pair(input bit wr_first, input logic [31:0] wa, input logic [31:0] ra, input logic [127:0] d);
    dcw_start_rq = 1'b1;
    dcr_start_rq = 1'b1;
    dcw_in_addr = wa;
    dcw_in_mask = 16'h00FF;
    dcw_in_data = d;
    dcr_rin_addr = ra;
    tick();
    dcw_start_rq = 1'b0;
    dcr_start_rq = 1'b0;
    #1;
    `CHK("pair_slots", {wqfull, rqfull_1}, 2'b11);
    `CHK("pair_not_yet", mem_cmd_valid, 0);
    tick();
    if (wr_first) begin
      serve_wr(wa, 16'h00FF, d, 1);
      serve_rd(ra, ~d);
    end else begin
      serve_rd(ra, ~d);
      serve_wr(wa, 16'h00FF, d, 1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {dcw_start_rq, dcr_start_rq, mem_wresp, mem_rvalid, mem_rlast, err_clr} = '0;
    dcw_in_addr = '0; dcw_in_mask = '0; dcw_in_data = '0; dcr_rin_addr = '0; mem_rdata = '0;
    mem_cmd_ready = 1'b1;
    tick();
    tick();
    `CHK("rst_outs", |{dcw_finish_wresp, rdat_m_data, rdat_m_valid, finish_mrd, rqfull_1, wqfull,
                      mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_mask, mem_cmd_wdata, ovf_err, tmo_err}, 0);
    rst_n = 1'b1;
    tick();
    pair(1'b1, 32'h0000_2000, 32'h0000_3000, 128'hA5A5_0001_0000_0000_0000_0000_DEAD_BEEF);
    pair(1'b1, 32'h0000_2010, 32'h0000_3010, 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978);
    dcw_start_rq = 1'b1;
    dcw_in_addr = 32'h0000_1000;
    dcw_in_mask = 16'hFFFF;
    dcw_in_data = 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555;
    tick();
    dcw_start_rq = 1'b0;
    #1;
    `CHK("w1_slot", wqfull, 1);
    `CHK("w1_not_yet", mem_cmd_valid, 0);
    tick();
    serve_wr(32'h0000_1000, 16'hFFFF, 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555, 3);
    pair(1'b0, 32'h0000_2020, 32'h0000_3020, 128'h0000_0000_FFFF_FFFF_0000_0000_FFFF_FFFF);
    dcr_start_rq = 1'b1;
    dcr_rin_addr = 32'h0000_4000;
    tick();
    dcr_start_rq = 1'b0;
    #1;
    `CHK("b_slot", rqfull_1, 1);
    tick();
    #1;
    `CHK("b_cmd_addr", mem_cmd_addr, 32'h0000_4000);
    tick();
    `CHK("b_slot_clr", rqfull_1, 0);
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = 1'b1;
      mem_rlast = i == 3;
      mem_rdata = {4{32'(i * 32'h1111_0101)}};
      #1;
      total++;
      if (rdat_m_valid === 1'b1) passed++;
      else $error("FAIL b_beat_valid: observed %0b at beat %0d", rdat_m_valid, i);
      total++;
      if (rdat_m_data === {4{32'(i * 32'h1111_0101)}}) passed++;
      else $error("FAIL b_beat_data: observed %0h at beat %0d", rdat_m_data, i);
      total++;
      if (finish_mrd === (i == 3)) passed++;
      else $error("FAIL b_finish: observed %0b at beat %0d", finish_mrd, i);
      tick();
    end
    mem_rlast = 1'b0;
    #1;
    `CHK("idle_rvalid_ignored", rdat_m_valid, 0);
    `CHK("idle_no_finish", finish_mrd, 0);
    mem_rvalid = 1'b0;
    tick();
    mem_cmd_ready = 1'b0;
    dcr_start_rq = 1'b1;
    dcr_rin_addr = 32'h0000_5000;
    tick();
    dcr_start_rq = 1'b0;
    tick();
    #1;
    `CHK("o_cmd_addr", mem_cmd_addr, 32'h0000_5000);
    dcr_start_rq = 1'b1;
    dcr_rin_addr = 32'h0000_6000;
    tick();
    dcr_start_rq = 1'b0;
    #1;
    `CHK("o_ovf_set", ovf_err, 1);
    `CHK("o_addr_kept", mem_cmd_addr, 32'h0000_5000);
    `CHK("o_slot_kept", rqfull_1, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    `CHK("o_ovf_clr", ovf_err, 0);
    mem_cmd_ready = 1'b1;
    tick();
    for (int k = 1; k < 15; k++) begin
      total++;
      if (finish_mrd === 1'b0) passed++;
      else $error("FAIL t_no_finish: observed %0b at wait cycle %0d", finish_mrd, k);
      tick();
    end
    `CHK("t_finish", finish_mrd, 1);
    `CHK("t_err_not_yet", tmo_err, 0);
    tick();
    `CHK("t_err_set", tmo_err, 1);
    `CHK("t_finish_once", finish_mrd, 0);
    mem_rvalid = 1'b1;
    mem_rlast = 1'b1;
    #1;
    `CHK("t_idle_rvalid", rdat_m_valid, 0);
    mem_rvalid = 1'b0;
    mem_rlast = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    `CHK("t_err_clr", tmo_err, 0);
    dcw_start_rq = 1'b1;
    dcw_in_addr = 32'h0000_7000;
    dcw_in_mask = 16'h0F0F;
    dcw_in_data = 128'h7777;
    tick();
    dcw_start_rq = 1'b0;
    tick();
    dcw_start_rq = 1'b1;
    dcw_in_addr = 32'h0000_8000;
    dcw_in_mask = 16'hF0F0;
    dcw_in_data = 128'h8888;
    #1;
    `CHK("s_old_addr", mem_cmd_addr, 32'h0000_7000);
    tick();
    dcw_start_rq = 1'b0;
    #1;
    `CHK("s_slot_kept", wqfull, 1);
    `CHK("s_no_ovf", ovf_err, 0);
    mem_wresp = 1'b1;
    #1;
    `CHK("s_finish", dcw_finish_wresp, 1);
    tick();
    mem_wresp = 1'b0;
    tick();
    serve_wr(32'h0000_8000, 16'hF0F0, 128'h8888, 1);
    dcr_start_rq = 1'b1;
    dcr_rin_addr = 32'h0000_9000;
    tick();
    dcr_start_rq = 1'b0;
    tick();
    tick();
    mem_rvalid = 1'b1;
    mem_rdata = 128'h9999;
    #1;
    `CHK("r_beat_live", rdat_m_valid, 1);
    mem_rlast = 1'b1;
    rst_n = 1'b0;
    #1;
    `CHK("r_outs_zero", |{rdat_m_valid, rdat_m_data, finish_mrd, rqfull_1, wqfull, mem_cmd_valid}, 0);
    tick();
    rst_n = 1'b1;
    #1;
    `CHK("r_post_rvalid", rdat_m_valid, 0);
    `CHK("r_post_finish", finish_mrd, 0);
    tick();
    `CHK("r_post_idle", {rdat_m_valid, finish_mrd, mem_cmd_valid}, 3'b000);
    mem_rvalid = 1'b0;
    mem_rlast = 1'b0;
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
